// File: rtl/demux_stream_1to4_pkg.sv
// Shared definitions for the 1-to-4 stream scatter and its 4-to-1 gather counterpart.
// The lane encoding matches the selector's {s1,s0} encoding.
package demux_pkg;

    localparam int LANES      = 4;
    localparam int SEL_W      = 2;
    localparam int FIFO_DEPTH = 2;

    typedef enum logic [SEL_W-1:0] {
        LANE0 = 2'd0,
        LANE1 = 2'd1,
        LANE2 = 2'd2,
        LANE3 = 2'd3
    } lane_e;

endpackage

// File: rtl/demux_stream_1to4_lane_fifo2.sv
// Two-entry per-lane FIFO. The head sits in a fixed register, so dout never muxes on a pointer.
// The caller never pushes while full and never pops while empty.
module lane_fifo2 #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] din,
    input  logic              pop,
    output logic [DATA_W-1:0] dout,
    output logic              valid,
    output logic              full
);
    import demux_pkg::*;

    logic [1:0]        count_q, count_d;
    logic [DATA_W-1:0] head_q;
    logic [DATA_W-1:0] tail_q;

    always_comb begin
        count_d = count_q;
        unique case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
        end else begin
            count_q <= count_d;
        end
    end

    // Push+pop at count 1 moves the new beat straight into the head.
    always_ff @(posedge clk) begin
        if (push && (count_q == 2'd0 || (pop && count_q == 2'd1))) begin
            head_q <= din;
        end else if (pop) begin
            head_q <= tail_q;
        end
        if (push && !pop && count_q == 2'd1) begin
            tail_q <= din;
        end
    end

    assign dout  = head_q;
    assign valid = (count_q != 2'd0);
    assign full  = (count_q == 2'(FIFO_DEPTH));

endmodule

// File: rtl/demux_stream_1to4.sv
// Clocked 1-to-4 stream demultiplexer: routes each accepted beat to one lane FIFO,
// chosen by in_sel or by an internal round-robin pointer.
module demux_stream_1to4 #(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                rr_en,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_data,
    input  logic [1:0]          in_sel,
    output logic [3:0]          out_valid,
    input  logic [3:0]          out_ready,
    output logic [4*DATA_W-1:0] out_data,
    output logic [1:0]          rr_ptr
);
    import demux_pkg::*;

    // Handshake: a beat transfers on a rising edge where valid & ready; the source holds
    // data/select while valid & !ready. in_ready depends only on registered full flags and
    // the lane choice, never on out_ready.
    lane_e            lane_sel;
    logic             accept;
    logic [LANES-1:0] lane_full;
    logic [LANES-1:0] lane_push;
    logic [LANES-1:0] lane_pop;
    logic [1:0]       rr_ptr_q, rr_ptr_d;

    assign lane_sel = rr_en ? lane_e'(rr_ptr_q) : lane_e'(in_sel);
    assign in_ready = !lane_full[lane_sel];
    assign accept   = in_valid && in_ready;

    for (genvar k = 0; k < LANES; k++) begin : g_lane
        assign lane_push[k] = accept && (lane_sel == lane_e'(k));
        assign lane_pop[k]  = out_valid[k] && out_ready[k];

        lane_fifo2 #(.DATA_W(DATA_W)) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (lane_push[k]),
            .din   (in_data),
            .pop   (lane_pop[k]),
            .dout  (out_data[k*DATA_W +: DATA_W]),
            .valid (out_valid[k]),
            .full  (lane_full[k])
        );
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept && rr_en) begin
            rr_ptr_d = rr_ptr_q + 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    assign rr_ptr = rr_ptr_q;

endmodule

// File: tb/tb_demux_stream_1to4.sv
// Directed bench for demux_stream_1to4: hand-computed vectors plus per-lane expected queues
// that every popped beat is compared against.
module tb_demux_stream_1to4;

    logic        clk;
    logic        rst_n;
    logic        rr_en;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_data;
    logic [1:0]  in_sel;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [31:0] out_data;
    logic [1:0]  rr_ptr;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[4][$];

    demux_stream_1to4 #(.DATA_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .rr_en     (rr_en),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .rr_ptr    (rr_ptr)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] sel, input logic [7:0] d);
        in_valid = v;
        in_sel   = sel;
        in_data  = d;
        #1;
    endtask

    function automatic logic [7:0] lane_data(input int k);
        return out_data[k*8 +: 8];
    endfunction

    // scoreboard: every pop must match the oldest expected beat of that lane
    always @(negedge clk) begin
        if (rst_n) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) chk($sformatf("pop_unexpected_l%0d", k), 32'd1, 32'd0);
                    else chk($sformatf("pop_data_l%0d", k), {24'd0, lane_data(k)}, {24'd0, exp_q[k].pop_front()});
                end
            end
        end
    end

    logic [7:0] t1_vals[4];

    initial begin
        rst_n     = 1'b0;
        rr_en     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 8'h00;
        in_sel    = 2'd0;
        out_ready = 4'h0;
        t1_vals   = '{8'h11, 8'h22, 8'h33, 8'h44};
        repeat (3) tick();
        chk("rst_out_valid", {28'd0, out_valid}, 32'd0);
        chk("rst_rr_ptr", {30'd0, rr_ptr}, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
        rst_n = 1'b1;
        tick();

        // Test 1: selected lanes, one beat each, all consumers ready
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), t1_vals[k]);
            chk("t1_in_ready", {31'd0, in_ready}, 32'd1);
            exp_q[k].push_back(t1_vals[k]);
            tick();
            chk("t1_out_valid", {28'd0, out_valid}, 32'd1 << k);
            chk("t1_head", {24'd0, lane_data(k)}, {24'd0, t1_vals[k]});
        end
        drive(1'b0, 2'd0, 8'h00);
        tick();
        chk("t1_drained", {28'd0, out_valid}, 32'd0);

        // Test 2: lane 2 stalls; other lanes still flow
        out_ready = 4'b1011;
        drive(1'b1, 2'd2, 8'hA0);
        chk("t2_rdy_a0", {31'd0, in_ready}, 32'd1);
        exp_q[2].push_back(8'hA0);
        tick();
        drive(1'b1, 2'd2, 8'hA1);
        chk("t2_rdy_a1", {31'd0, in_ready}, 32'd1);
        exp_q[2].push_back(8'hA1);
        tick();
        drive(1'b1, 2'd2, 8'hA2);
        chk("t2_rdy_a2_full", {31'd0, in_ready}, 32'd0);
        chk("t2_head_a0", {24'd0, lane_data(2)}, 32'hA0);
        drive(1'b1, 2'd0, 8'h0C);
        chk("t2_rdy_lane0", {31'd0, in_ready}, 32'd1);
        exp_q[0].push_back(8'h0C);
        tick();
        chk("t2_valid_02", {28'd0, out_valid}, 32'b0101);
        chk("t2_head_hold", {24'd0, lane_data(2)}, 32'hA0);
        out_ready = 4'hF;
        drive(1'b1, 2'd2, 8'hA2);
        chk("t2_rdy_full_pop", {31'd0, in_ready}, 32'd0);
        tick();
        chk("t2_rdy_after_pop", {31'd0, in_ready}, 32'd1);
        chk("t2_head_a1", {24'd0, lane_data(2)}, 32'hA1);
        exp_q[2].push_back(8'hA2);
        tick();
        chk("t2_head_a2", {24'd0, lane_data(2)}, 32'hA2);
        chk("t2_valid_2", {28'd0, out_valid}, 32'b0100);
        drive(1'b0, 2'd0, 8'h00);
        tick();
        chk("t2_drained", {28'd0, out_valid}, 32'd0);

        // Test 3: round-robin distribution
        rr_en = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 2'd3, 8'(i));
            chk("t3_rr_ptr", {30'd0, rr_ptr}, 32'(i % 4));
            chk("t3_in_ready", {31'd0, in_ready}, 32'd1);
            exp_q[i % 4].push_back(8'(i));
            tick();
            chk("t3_out_valid", {28'd0, out_valid}, 32'd1 << (i % 4));
        end
        drive(1'b0, 2'd0, 8'h00);
        chk("t3_rr_end", {30'd0, rr_ptr}, 32'd2);
        repeat (2) tick();
        chk("t3_rr_gap_hold", {30'd0, rr_ptr}, 32'd2);
        chk("t3_drained", {28'd0, out_valid}, 32'd0);

        // Test 4: push+pop at count 1 on lane 1
        rr_en = 1'b0;
        out_ready = 4'b1101;
        drive(1'b1, 2'd1, 8'h54);
        exp_q[1].push_back(8'h54);
        tick();
        out_ready = 4'hF;
        drive(1'b1, 2'd1, 8'h55);
        chk("t4_in_ready", {31'd0, in_ready}, 32'd1);
        chk("t4_rr_hold_sel", {30'd0, rr_ptr}, 32'd2);
        exp_q[1].push_back(8'h55);
        tick();
        chk("t4_valid", {28'd0, out_valid}, 32'b0010);
        chk("t4_head_55", {24'd0, lane_data(1)}, 32'h55);
        out_ready = 4'b1101;
        drive(1'b0, 2'd0, 8'h00);
        tick();
        chk("t4_still_one", {28'd0, out_valid}, 32'b0010);
        out_ready = 4'hF;
        tick();
        chk("t4_count_was_1", {28'd0, out_valid}, 32'd0);

        // Test 5: full lane refuses push even while popping
        out_ready = 4'b0111;
        drive(1'b1, 2'd3, 8'h7E);
        exp_q[3].push_back(8'h7E);
        tick();
        drive(1'b1, 2'd3, 8'h7F);
        exp_q[3].push_back(8'h7F);
        tick();
        out_ready = 4'hF;
        drive(1'b1, 2'd3, 8'h80);
        chk("t5_refused", {31'd0, in_ready}, 32'd0);
        tick();
        chk("t5_head_7f", {24'd0, lane_data(3)}, 32'h7F);
        chk("t5_valid", {28'd0, out_valid}, 32'b1000);
        chk("t5_rdy_again", {31'd0, in_ready}, 32'd1);
        drive(1'b0, 2'd0, 8'h00);
        tick();
        chk("t5_drained", {28'd0, out_valid}, 32'd0);

        // Test 6: asynchronous reset mid-stream
        out_ready = 4'h0;
        rr_en = 1'b1;
        drive(1'b1, 2'd0, 8'h91);
        tick();
        rr_en = 1'b0;
        drive(1'b1, 2'd0, 8'h92);
        tick();
        drive(1'b0, 2'd0, 8'h00);
        chk("t6_pre_rr", {30'd0, rr_ptr}, 32'd3);
        chk("t6_pre_valid", {28'd0, out_valid}, 32'b0101);
        #1;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", {28'd0, out_valid}, 32'd0);
        chk("t6_rst_rr", {30'd0, rr_ptr}, 32'd0);
        for (int k = 0; k < 4; k++) exp_q[k].delete();
        tick();
        tick();
        rst_n = 1'b1;
        out_ready = 4'hF;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 2'(k), 8'h00);
            in_valid = 1'b0;
            #1;
            chk("t6_rdy_sel", {31'd0, in_ready}, 32'd1);
        end
        rr_en = 1'b1;
        #1;
        chk("t6_rdy_rr", {31'd0, in_ready}, 32'd1);
        rr_en = 1'b0;
        repeat (2) tick();
        chk("t6_no_stale", {28'd0, out_valid}, 32'd0);
        drive(1'b1, 2'd2, 8'h3C);
        exp_q[2].push_back(8'h3C);
        tick();
        drive(1'b0, 2'd0, 8'h00);
        chk("t6_fresh_valid", {28'd0, out_valid}, 32'b0100);
        chk("t6_fresh_head", {24'd0, lane_data(2)}, 32'h3C);
        tick();
        tick();

        for (int k = 0; k < 4; k++) chk($sformatf("drain_q%0d", k), exp_q[k].size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
